// File: rtl/cpu_sequencer_if.sv
// Sequencer-to-datapath bundle: instruction-memory port plus the decoder and datapath enables.
// The master side is the sequencer; the slave side is the ROM/decoder/register-file/ALU datapath.
interface cpu_sequencer_if #(
   parameter int unsigned PC_WIDTH = 8
);
   logic [PC_WIDTH-1:0] imem_addr;
   logic                imem_rd_en;
   logic [15:0]         imem_rdata;
   logic [15:0]         instr;
   logic                rf_rd_en;
   logic                alu_en;
   logic                rf_wr_en;

   modport master (
      output imem_addr,
      output imem_rd_en,
      input  imem_rdata,
      output instr,
      output rf_rd_en,
      output alu_en,
      output rf_wr_en
   );

   modport slave (
      input  imem_addr,
      input  imem_rd_en,
      output imem_rdata,
      input  instr,
      input  rf_rd_en,
      input  alu_en,
      input  rf_wr_en
   );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle control unit: FETCH/LATCH/DECODE/EXEC/WB sequencing with free-run and
// push-button single-step modes. Enables are decoded from registered state only.
module cpu_sequencer #(
   parameter int unsigned PC_WIDTH = 8,
   parameter logic [3:0]  HALT_OP  = 4'hF,
   parameter logic [3:0]  JMP_OP   = 4'hE,
   parameter logic [3:0]  NOWB_OP  = 4'h0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  btn,
   input  logic                  run,
   cpu_sequencer_if.master       bus,
   output logic                  halted,
   output logic [15:0]           retire_cnt,
   output logic [2:0]            state
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] FETCH  = 3'd1;
   localparam logic [2:0] LATCH  = 3'd2;
   localparam logic [2:0] DECODE = 3'd3;
   localparam logic [2:0] EXEC   = 3'd4;
   localparam logic [2:0] WB     = 3'd5;
   localparam logic [2:0] HALT   = 3'd6;

   logic [2:0]          state_q, state_d;
   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic [15:0]         instr_q, instr_d;
   logic [15:0]         retire_cnt_q, retire_cnt_d;
   logic [2:0]          btn_sync_q;
   logic                step_pulse;
   logic [3:0]          opcode;
   logic                is_jmp;
   logic                is_nowb;

   // btn_sync_q[1:0] is the 2-FF synchroniser; btn_sync_q[2] holds the previous synced level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_sync_q <= 3'b000;
      end else begin
         btn_sync_q <= {btn_sync_q[1:0], btn};
      end
   end

   assign step_pulse = btn_sync_q[1] & ~btn_sync_q[2];

   assign opcode  = instr_q[15:12];
   assign is_jmp  = (opcode == JMP_OP);
   assign is_nowb = (opcode == NOWB_OP);

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      instr_d      = instr_q;
      retire_cnt_d = retire_cnt_q;
      unique case (state_q)
         IDLE: begin
            if (run || step_pulse) begin
               state_d = FETCH;
            end
         end
         FETCH: begin
            state_d = LATCH;
         end
         LATCH: begin
            instr_d = bus.imem_rdata;
            state_d = DECODE;
         end
         DECODE: begin
            state_d = (opcode == HALT_OP) ? HALT : EXEC;
         end
         EXEC: begin
            state_d = WB;
         end
         WB: begin
            pc_d         = is_jmp ? instr_q[PC_WIDTH-1:0]
                                  : pc_q + {{(PC_WIDTH-1){1'b0}}, 1'b1};
            retire_cnt_d = retire_cnt_q + 16'd1;
            // run is only sampled here and in IDLE; step pulses arriving now are dropped.
            state_d      = run ? FETCH : IDLE;
         end
         HALT: begin
            state_d = HALT;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         pc_q         <= '0;
         instr_q      <= 16'h0000;
         retire_cnt_q <= 16'h0000;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         instr_q      <= instr_d;
         retire_cnt_q <= retire_cnt_d;
      end
   end

   always_comb begin
      bus.imem_rd_en = (state_q == FETCH);
      bus.rf_rd_en   = (state_q == DECODE) && (opcode != HALT_OP);
      bus.alu_en     = (state_q == EXEC);
      bus.rf_wr_en   = (state_q == WB) && !is_jmp && !is_nowb;
      halted         = (state_q == HALT);
   end

   assign bus.imem_addr = pc_q;
   assign bus.instr     = instr_q;
   assign retire_cnt    = retire_cnt_q;
   assign state         = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: instruction-level reference model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_cpu_sequencer;

   localparam int unsigned PW = 8;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        btn   = 1'b0;
   logic        run   = 1'b0;
   logic        halted;
   logic [15:0] retire_cnt;
   logic [2:0]  state;

   cpu_sequencer_if #(.PC_WIDTH(PW)) bus ();

   cpu_sequencer #(.PC_WIDTH(PW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .btn        (btn),
      .run        (run),
      .bus        (bus),
      .halted     (halted),
      .retire_cnt (retire_cnt),
      .state      (state)
   );

   always #5 clk = ~clk;

   // Synchronous instruction ROM: data valid the cycle after the read strobe.
   logic [15:0] rom [256];
   always @(posedge clk) begin
      if (bus.imem_rd_en) bus.imem_rdata <= rom[bus.imem_addr];
   end

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_timeout(input string name);
      n_chk++;
      n_err++;
      $display("FAIL %s: timed out waiting at %0t", name, $time);
   endtask

   // ---------------- reference model: expands each instruction into its cycle sequence
   typedef struct packed {
      logic [2:0]  st;
      logic        rd, rf, alu, wr, hlt;
      logic [7:0]  pc;
      logic [15:0] ins;
      logic [15:0] ret;
   } rec_t;

   logic [7:0]  m_pc;
   logic [15:0] m_ins, m_ret;
   logic        s1, s2, s3;
   rec_t        cur;
   rec_t        sched [$];
   int          pre_cnt = 0, pre_seen = 0;
   logic [15:0] pre_val = 16'h0;

   function automatic rec_t mk(input logic [2:0] st, input logic rd, input logic rf,
                               input logic alu, input logic wr, input logic hlt,
                               input logic [7:0] pc, input logic [15:0] ins,
                               input logic [15:0] ret);
      rec_t r;
      r.st = st; r.rd = rd; r.rf = rf; r.alu = alu; r.wr = wr; r.hlt = hlt;
      r.pc = pc; r.ins = ins; r.ret = ret;
      return r;
   endfunction

   function automatic rec_t idle_rec();
      return mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, m_pc, m_ins, m_ret);
   endfunction

   task automatic m_reset();
      m_pc = 8'h00; m_ins = 16'h0; m_ret = 16'h0;
      s1 = 1'b0; s2 = 1'b0; s3 = 1'b0;
      sched.delete();
      cur = idle_rec();
   endtask

   task automatic m_build();
      logic [15:0] w;
      logic [3:0]  op;
      w  = rom[m_pc];
      op = w[15:12];
      sched.push_back(mk(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, m_pc, m_ins, m_ret));
      sched.push_back(mk(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, m_pc, m_ins, m_ret));
      m_ins = w;
      if (op == 4'hF) begin
         sched.push_back(mk(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, m_pc, w, m_ret));
         sched.push_back(mk(3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, m_pc, w, m_ret));
      end else begin
         sched.push_back(mk(3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, m_pc, w, m_ret));
         sched.push_back(mk(3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, m_pc, w, m_ret));
         sched.push_back(mk(3'd5, 1'b0, 1'b0, 1'b0, (op != 4'hE) && (op != 4'h0), 1'b0,
                            m_pc, w, m_ret));
         m_pc  = (op == 4'hE) ? w[7:0] : m_pc + 8'd1;
         m_ret = m_ret + 16'd1;
      end
   endtask

   task automatic m_step();
      logic pulse;
      pulse = s2 & ~s3;
      if (pre_cnt != pre_seen) begin
         pre_seen = pre_cnt;
         m_ret    = pre_val;
      end
      if (sched.size() != 0) begin
         cur = sched.pop_front();
      end else if ((cur.st == 3'd0 && (run || pulse)) || (cur.st == 3'd5 && run)) begin
         m_build();
         cur = sched.pop_front();
      end else if (cur.st != 3'd6) begin
         cur = idle_rec();
      end
      s3 = s2; s2 = s1; s1 = btn;
   endtask

   initial begin
      m_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) m_reset();
         else m_step();
      end
   end

   // Every-cycle comparison against the model.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            check("state",      32'(state),          32'(cur.st));
            check("imem_rd_en", 32'(bus.imem_rd_en), 32'(cur.rd));
            check("rf_rd_en",   32'(bus.rf_rd_en),   32'(cur.rf));
            check("alu_en",     32'(bus.alu_en),     32'(cur.alu));
            check("rf_wr_en",   32'(bus.rf_wr_en),   32'(cur.wr));
            check("halted",     32'(halted),         32'(cur.hlt));
            check("imem_addr",  32'(bus.imem_addr),  32'(cur.pc));
            check("instr",      32'(bus.instr),      32'(cur.ins));
            check("retire_cnt", 32'(retire_cnt),     32'(cur.ret));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // ---------------- directed scenarios
   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic fill(input logic [15:0] v);
      for (int i = 0; i < 256; i++) rom[i] = v;
   endtask

   task automatic hold_reset();
      rst_n = 1'b0;
      btn   = 1'b0;
      @(negedge clk);
   endtask

   int          nwr;
   int          cyc;
   int          wr_at [2];
   logic [15:0] wr_ins [2];
   logic        seen_jmp, seen_tgt;

   initial begin
      fill(16'hF000);
      // Reset values
      hold_reset();
      cycles(1);
      check("rst_state",  32'(state),         32'd0);
      check("rst_pc",     32'(bus.imem_addr), 32'd0);
      check("rst_instr",  32'(bus.instr),     32'd0);
      check("rst_retire", 32'(retire_cnt),    32'd0);
      check("rst_halted", 32'(halted),        32'd0);
      check("rst_rd_en",  32'(bus.imem_rd_en), 32'd0);

      // 1: free-run, two instructions then halt
      run = 1'b1;
      rom[0] = 16'h2372; rom[1] = 16'hC844; rom[2] = 16'hF000;
      rst_n = 1'b1;
      nwr = 0; cyc = 0;
      while (state != 3'd6 && cyc < 60) begin
         @(negedge clk);
         cyc++;
         if (bus.rf_wr_en) begin
            if (nwr < 2) begin
               wr_at[nwr]  = cyc;
               wr_ins[nwr] = bus.instr;
            end
            nwr++;
         end
      end
      if (state != 3'd6) fail_timeout("s1_halt");
      check("s1_wr_count",  32'(nwr),                 32'd2);
      check("s1_wr_gap",    32'(wr_at[1] - wr_at[0]), 32'd5);
      check("s1_instr0",    32'(wr_ins[0]),           32'h2372);
      check("s1_instr1",    32'(wr_ins[1]),           32'hC844);
      check("s1_halted",    32'(halted),              32'd1);
      check("s1_retire",    32'(retire_cnt),          32'd2);
      check("s1_pc",        32'(bus.imem_addr),       32'd2);
      check("s1_state",     32'(state),               32'd6);
      cycles(5);
      check("s1_halt_hold", 32'(state),               32'd6);

      // 2: single-step, held button gives exactly one step
      hold_reset();
      run = 1'b0;
      fill(16'hF000);
      rom[0] = 16'h1018; rom[1] = 16'h3456; rom[2] = 16'h7777;
      rst_n = 1'b1;
      btn = 1'b1;
      cycles(30);
      btn = 1'b0;
      cycles(2);
      check("s2_state",   32'(state),         32'd0);
      check("s2_retire",  32'(retire_cnt),    32'd1);
      check("s2_pc",      32'(bus.imem_addr), 32'd1);
      btn = 1'b1;
      cycles(3);
      btn = 1'b0;
      cycles(12);
      check("s2_retire2", 32'(retire_cnt),    32'd2);
      check("s2_pc2",     32'(bus.imem_addr), 32'd2);

      // 3: a step pulse landing in EXEC is dropped
      btn = 1'b1;
      cycles(1);
      btn = 1'b0;
      cyc = 0;
      while (state != 3'd2 && cyc < 10) begin
         @(negedge clk);
         cyc++;
      end
      if (state != 3'd2) fail_timeout("s3_latch");
      btn = 1'b1;
      cycles(1);
      btn = 1'b0;
      cycles(15);
      check("s3_retire", 32'(retire_cnt),    32'd3);
      check("s3_pc",     32'(bus.imem_addr), 32'd3);
      check("s3_state",  32'(state),         32'd0);

      // 4a: absolute jump suppresses writeback and redirects fetch
      hold_reset();
      run = 1'b1;
      fill(16'hF000);
      rom[0] = 16'h1111; rom[1] = 16'h2222; rom[2] = 16'h3333; rom[3] = 16'hE00A;
      rst_n = 1'b1;
      seen_jmp = 1'b0; seen_tgt = 1'b0; cyc = 0;
      while (state != 3'd6 && cyc < 60) begin
         @(negedge clk);
         cyc++;
         if (state == 3'd5 && bus.instr == 16'hE00A) begin
            check("s4_jmp_wr", 32'(bus.rf_wr_en), 32'd0);
            seen_jmp = 1'b1;
         end else if (seen_jmp && !seen_tgt && state == 3'd1) begin
            check("s4_jmp_target", 32'(bus.imem_addr), 32'h0A);
            seen_tgt = 1'b1;
         end
      end
      if (!seen_tgt) fail_timeout("s4_jmp");
      check("s4_pc",     32'(bus.imem_addr), 32'h0A);
      check("s4_retire", 32'(retire_cnt),    32'd4);

      // 4b: NOP retires without writeback
      hold_reset();
      fill(16'hF000);
      for (int i = 0; i < 5; i++) rom[i] = 16'h1000;
      rom[5] = 16'h0000;
      rst_n = 1'b1;
      nwr = 0; cyc = 0;
      while (state != 3'd6 && cyc < 80) begin
         @(negedge clk);
         cyc++;
         if (bus.rf_wr_en) nwr++;
      end
      if (state != 3'd6) fail_timeout("s4b_halt");
      check("s4b_wr_count", 32'(nwr),            32'd5);
      check("s4b_pc",       32'(bus.imem_addr), 32'd6);
      check("s4b_retire",   32'(retire_cnt),    32'd6);

      // 5: pc wrap from FF and retire counter wrap
      hold_reset();
      fill(16'hF000);
      rom[0] = 16'hE0FF; rom[255] = 16'h1234;
      rst_n = 1'b1;
      cyc = 0;
      while (!(state == 3'd5 && bus.instr == 16'h1234) && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      if (!(state == 3'd5 && bus.instr == 16'h1234)) fail_timeout("s5_wb");
      @(negedge clk);
      check("s5_wrap_pc",    32'(bus.imem_addr), 32'h00);
      check("s5_wrap_state", 32'(state),         32'd1);
      run = 1'b0;
      cyc = 0;
      while (state != 3'd0 && cyc < 10) begin
         @(negedge clk);
         cyc++;
      end
      if (state != 3'd0) fail_timeout("s5_park");
      check("s5_park_pc", 32'(bus.imem_addr), 32'hFF);
      #2;
      force dut.retire_cnt_q = 16'hFFFE;
      pre_val = 16'hFFFE;
      pre_cnt++;
      @(negedge clk);
      #2;
      release dut.retire_cnt_q;
      @(negedge clk);
      check("s5_preload", 32'(retire_cnt), 32'hFFFE);
      btn = 1'b1;
      cycles(2);
      btn = 1'b0;
      cycles(10);
      check("s5_retire_ffff", 32'(retire_cnt),    32'hFFFF);
      check("s5_step_wrap",   32'(bus.imem_addr), 32'h00);
      btn = 1'b1;
      cycles(2);
      btn = 1'b0;
      cycles(10);
      check("s5_retire_wrap", 32'(retire_cnt),    32'h0000);
      check("s5_pc_ff",       32'(bus.imem_addr), 32'hFF);

      // 6: asynchronous reset in EXEC abandons the instruction
      hold_reset();
      run = 1'b1;
      fill(16'h1234);
      rst_n = 1'b1;
      cyc = 0;
      while (!(retire_cnt >= 16'd2 && state == 3'd4) && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      if (!(retire_cnt >= 16'd2 && state == 3'd4)) fail_timeout("s6_exec");
      check("s6_alu_before", 32'(bus.alu_en), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("s6_alu",    32'(bus.alu_en),    32'd0);
      check("s6_state",  32'(state),         32'd0);
      check("s6_pc",     32'(bus.imem_addr), 32'd0);
      check("s6_instr",  32'(bus.instr),     32'd0);
      check("s6_retire", 32'(retire_cnt),    32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      cycles(20);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Multi-cycle control unit for the custom-ISA CPU. It fetches 16-bit instructions from instruction memory, holds them in an instruction register feeding the ISA decoder, and sequences register-file read, ALU execute and writeback enables. It supports free-running mode and single-step mode driven by the board push-button. It sits between the instruction ROM and the decoder/register-file/ALU datapath.

Parameters:
PC_WIDTH, 8, width of program counter and instruction-memory address
HALT_OP, 4'hF, opcode that stops the sequencer
JMP_OP, 4'hE, opcode for an absolute jump; target = instr[7:0] (low PC_WIDTH bits)
NOWB_OP, 4'h0, NOP opcode; suppresses writeback

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
btn  input  1  raw step push-button, asynchronous to clk
run  input  1  1 = free-run, 0 = single-step
imem_addr  output  PC_WIDTH  instruction memory address (= pc)
imem_rd_en  output  1  instruction memory read strobe
imem_rdata  input  16  instruction word, valid the cycle after imem_rd_en
instr  output  16  instruction register, drives the decoder
rf_rd_en  output  1  register-file read enable (rd and rs)
alu_en  output  1  ALU execute enable
rf_wr_en  output  1  register-file writeback enable
halted  output  1  sticky halt flag
retire_cnt  output  16  retired-instruction counter
state  output  3  current FSM state, for debug LEDs

Behaviour:
- Reset (rst_n=0, async): state=IDLE, pc=0, instr=16'h0000, all enables 0, halted=0, retire_cnt=0, button synchroniser cleared. Reset takes effect mid-instruction with no completion of the current instruction.
- btn: 2-FF synchroniser, then rising-edge detect producing a 1-cycle step pulse. Holding btn high produces exactly one pulse.
- State encoding: IDLE=0, FETCH=1, LATCH=2, DECODE=3, EXEC=4, WB=5, HALT=6.
- IDLE: all enables 0. Go to FETCH if run=1 or a step pulse is present; otherwise stay.
- FETCH: imem_rd_en=1, imem_addr=pc. Next state LATCH.
- LATCH: instr <= imem_rdata at the end of the cycle. Next state DECODE.
- DECODE: if instr[15:12]==HALT_OP, go to HALT with no enables. Otherwise rf_rd_en=1 and next state EXEC.
- EXEC: alu_en=1. Next state WB.
- WB:
  - rf_wr_en=1 unless the opcode is JMP_OP or NOWB_OP.
  - pc <= instr[PC_WIDTH-1:0] if JMP_OP, else pc+1, wrapping from 2^PC_WIDTH-1 to 0.
  - retire_cnt increments and wraps at 16'hFFFF to 0.
  - Next state FETCH if run=1, else IDLE.
- HALT: halted=1, all enables 0. pc and instr hold their values. Only rst_n exits.
- Latency and timing:
  - Each non-halt instruction takes exactly 5 cycles, FETCH through WB.
  - Exactly one of imem_rd_en, rf_rd_en, alu_en, rf_wr_en is high in its state; none outside it.
  - All outputs are registered or decoded from state only; none depend combinationally on imem_rdata.
- Single-step mode:
  - A step pulse in any state other than IDLE is ignored; pulses are not queued.
  - A step pulse on the same cycle WB returns to IDLE is also ignored.
- Run changes mid-instruction: run is sampled only in IDLE and WB. Dropping run mid-instruction completes that instruction, then the FSM parks in IDLE.

Test Plan:
1. Reset, run=1, ROM[0]=16'h2372, ROM[1]=16'hC844, ROM[2]=16'hF000 -> instr loads 2372 then C844. rf_wr_en pulses once per instruction, 5 cycles apart. In HALT: halted=1, retire_cnt=2, pc=2, state=6.
2. run=0, ROM[0]=16'h1018; assert btn for 30 cycles -> exactly one instruction executes, state returns to 0, retire_cnt=1, pc=1. A second btn press executes ROM[1].
3. btn pulsed again while state=EXEC -> ignored; retire_cnt rises only by 1.
4. ROM[3]=16'hE00A (JMP) -> rf_wr_en stays 0 in WB; next imem_addr=8'h0A. ROM[5]=16'h0000 (NOP) -> no rf_wr_en, pc=6.
5. pc=8'hFF executing a non-jump -> pc wraps to 8'h00. Preload retire_cnt to FFFF via 65535 NOPs (or force) -> wraps to 0.
6. rst_n pulsed low during EXEC -> alu_en drops immediately; state=0, pc=0, instr=0, retire_cnt=0.
